// File: rtl/hazard_lights_param.sv
// hazard_lights_param
//   Hazard / wind-indicator light sequencer. NUM_LIGHTS lamps are driven by a
//   Moore pattern FSM that advances once every TICK_DIV clocks. The mode input
//   picks one of four patterns: calm, right-to-left, left-to-right or flash.
//
// Ports
//   clk     in   1           system clock, rising edge
//   reset   in   1           asynchronous, active-high reset
//   mode    in   2           00 CALM, 01 R2L, 10 L2R, 11 FLASH (sampled on steps)
//   lights  out  NUM_LIGHTS  registered lamp drive, bit 0 = rightmost lamp
//   step    out  1           high in each cycle whose rising edge advances lights
module hazard_lights_param #(
  parameter int unsigned NUM_LIGHTS = 3,
  parameter int unsigned TICK_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic                  step
);

  typedef enum logic [1:0] {
    CALM  = 2'b00,
    R2L   = 2'b01,
    L2R   = 2'b10,
    FLASH = 2'b11
  } mode_e;

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [NUM_LIGHTS-1:0] LSB_ONLY = {{(NUM_LIGHTS-1){1'b0}}, 1'b1};
  localparam logic [NUM_LIGHTS-1:0] MSB_ONLY = {1'b1, {(NUM_LIGHTS-1){1'b0}}};
  localparam logic [NUM_LIGHTS-1:0] ENDS     = LSB_ONLY | MSB_ONLY;
  localparam logic [NUM_LIGHTS-1:0] INNER    = ~ENDS;

  logic [CNT_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic [NUM_LIGHTS-1:0] lights_q, lights_d;
  mode_e                 cur_mode_q, cur_mode_d;
  mode_e                 mode_in;
  logic                  pattern_ok;

  assign mode_in = mode_e'(mode);

  function automatic logic [NUM_LIGHTS-1:0] entry_pattern(input mode_e m);
    logic [NUM_LIGHTS-1:0] p;
    case (m)
      CALM:    p = ENDS;
      R2L:     p = LSB_ONLY;
      L2R:     p = MSB_ONLY;
      default: p = '1;
    endcase
    return p;
  endfunction

  // Prescaler. With TICK_DIV = 1 the counter is pinned at 0, which equals
  // TICK_DIV-1, so step is constantly 1 (including during reset).
  assign step = (tick_cnt_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    tick_cnt_d = tick_cnt_q + CNT_W'(1);
    if (step) begin
      tick_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Whether the current lamp value belongs to the running mode's pattern set;
  // anything else is replaced by the entry pattern on the next step.
  always_comb begin
    pattern_ok = 1'b0;
    case (cur_mode_q)
      CALM:     pattern_ok = (lights_q == ENDS) || (lights_q == INNER);
      R2L, L2R: pattern_ok = (lights_q != '0) &&
                             ((lights_q & (lights_q - LSB_ONLY)) == '0);
      default:  pattern_ok = (lights_q == '1) || (lights_q == '0);
    endcase
  end

  always_comb begin
    cur_mode_d = cur_mode_q;
    lights_d   = lights_q;
    if (step) begin
      if (mode_in != cur_mode_q) begin
        cur_mode_d = mode_in;
        lights_d   = entry_pattern(mode_in);
      end else if (!pattern_ok) begin
        lights_d   = entry_pattern(cur_mode_q);
      end else begin
        case (cur_mode_q)
          CALM:    lights_d = (lights_q == ENDS) ? INNER : ENDS;
          R2L:     lights_d = {lights_q[NUM_LIGHTS-2:0], lights_q[NUM_LIGHTS-1]};
          L2R:     lights_d = {lights_q[0], lights_q[NUM_LIGHTS-1:1]};
          default: lights_d = ~lights_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_mode_q <= CALM;
      lights_q   <= ENDS;
    end else begin
      cur_mode_q <= cur_mode_d;
      lights_q   <= lights_d;
    end
  end

  assign lights = lights_q;

endmodule

// File: tb/tb_hazard_lights_param.sv
module tb_hazard_lights_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       reset5;
  logic [1:0] mode;
  logic [1:0] mode5;
  logic [2:0] lights;
  logic       step;
  logic [4:0] lights5;
  logic       step5;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_q[$];
  logic [4:0] exp5_q[$];
  logic [2:0] cur_exp;

  always #5 clk = ~clk;

  hazard_lights_param #(.NUM_LIGHTS(3), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .mode(mode), .lights(lights), .step(step)
  );

  hazard_lights_param #(.NUM_LIGHTS(5), .TICK_DIV(1)) dut5 (
    .clk(clk), .reset(reset5), .mode(mode5), .lights(lights5), .step(step5)
  );

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Waits (bounded) for step, checking lights hold meanwhile, then checks the
  // value loaded on the step edge against the next scoreboard entry.
  task automatic step_check(input string tag, input int exp_wait);
    int         waited = 0;
    bit         seen = 0;
    logic [2:0] e;
    while (!seen && waited < 8) begin
      @(negedge clk);
      waited++;
      if (step === 1'b1) seen = 1;
      else chk({tag, " hold"}, 5'(lights), 5'(cur_exp));
    end
    if (!seen) begin
      chk({tag, " step timeout"}, 5'(step), 5'd1);
      return;
    end
    if (exp_wait > 0) chk({tag, " step delay"}, 5'(waited), 5'(exp_wait));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %b expected <scoreboard empty>", tag, lights);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 5'(lights), 5'(e));
      cur_exp = e;
    end
  endtask

  task automatic do_reset(input string tag, input logic [1:0] m);
    @(negedge clk);
    reset = 1'b1;
    mode  = m;
    @(negedge clk);
    chk({tag, " reset lights"}, 5'(lights), 5'b00101);
    chk({tag, " reset step"}, 5'(step), 5'd0);
    @(negedge clk);
    reset   = 1'b0;
    cur_exp = 3'b101;
  endtask

  initial begin
    reset  = 1'b1;
    reset5 = 1'b1;
    mode   = 2'b00;
    mode5  = 2'b00;
    cur_exp = 3'b101;
    #2;
    chk("async reset lights", 5'(lights), 5'b00101);
    chk("div1 reset lights", lights5, 5'b10001);
    chk("div1 reset step", 5'(step5), 5'd1);

    // Calm
    do_reset("calm", 2'b00);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b101);
    exp_q.push_back(3'b010);
    step_check("calm s1", 3);
    step_check("calm s2", 4);
    step_check("calm s3", 4);

    // R2L from release
    do_reset("r2l", 2'b01);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    step_check("r2l s1", 3);
    step_check("r2l s2", 4);
    step_check("r2l s3", 4);
    step_check("r2l wrap", 4);

    // L2R then FLASH
    mode = 2'b10;
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b100);
    step_check("l2r s1", 4);
    step_check("l2r s2", 4);
    step_check("l2r s3", 4);
    step_check("l2r wrap", 4);
    mode = 2'b11;
    exp_q.push_back(3'b111);
    exp_q.push_back(3'b000);
    exp_q.push_back(3'b111);
    step_check("flash s1", 4);
    step_check("flash s2", 4);
    step_check("flash s3", 4);

    // Mode change between steps with a one-cycle glitch
    mode = 2'b01;
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    step_check("glitch pre1", 4);
    step_check("glitch pre2", 4);
    @(negedge clk);
    chk("glitch hold0", 5'(lights), 5'(cur_exp));
    mode = 2'b11;
    @(negedge clk);
    chk("glitch hold1", 5'(lights), 5'(cur_exp));
    mode = 2'b01;
    @(negedge clk);
    chk("glitch hold2", 5'(lights), 5'(cur_exp));
    mode = 2'b10;
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b010);
    step_check("late change", 1);
    step_check("late change next", 4);

    // Async reset while step is high, between edges
    for (int i = 0; i < 8 && step !== 1'b1; i++) @(negedge clk);
    chk("pre-reset step", 5'(step), 5'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid reset lights", 5'(lights), 5'b00101);
    chk("mid reset step", 5'(step), 5'd0);
    @(negedge clk);
    chk("mid reset hold", 5'(lights), 5'b00101);
    @(negedge clk);
    reset   = 1'b0;
    cur_exp = 3'b101;
    exp_q.push_back(3'b100);
    step_check("post reset", 3);

    // NUM_LIGHTS=5, TICK_DIV=1
    @(negedge clk);
    reset5 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp5_q.push_back(5'b01110);
      exp5_q.push_back(5'b10001);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("div1 lights", lights5, exp5_q.pop_front());
      chk("div1 step", 5'(step5), 5'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
